// File: rtl/micro_sequencer.sv
// micro_sequencer: next-state engine of the microprogrammed control unit.
// Picks the next microstate from encoder / fetch entry / CR field / incrementer,
// steered by ns_ctl and a selectable, invertible condition (sts).
// Optional feature macro: SEQ_MOC_TIMEOUT_EN (bounds hold cycles, sets sticky
// moc_timeout and falls back to the fetch entry).
module micro_sequencer #(
    parameter int STATE_W     = 6,
    parameter int RESET_STATE = 0,
    parameter int FETCH_STATE = 1,
    parameter int MOC_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        instr,
    input  logic [2:0]         ns_ctl,
    input  logic [STATE_W-1:0] cr_next,
    input  logic               inv,
    input  logic [1:0]         cond_sel,
    input  logic               moc,
    input  logic               cond_pass,
    input  logic               ext_cond,
    output logic [STATE_W-1:0] state,
    output logic [1:0]         src_sel,
    output logic               moc_timeout
);

    localparam logic [STATE_W-1:0] RST_S   = STATE_W'(RESET_STATE);
    localparam logic [STATE_W-1:0] FETCH_S = STATE_W'(FETCH_STATE);

    typedef enum logic [1:0] {
        SRC_ENC   = 2'b00,
        SRC_FETCH = 2'b01,
        SRC_CR    = 2'b10,
        SRC_INC   = 2'b11
    } src_e;

    logic [STATE_W-1:0] state_q, state_d;
    logic [STATE_W-1:0] inc_q;
    logic [STATE_W-1:0] enc_state;
    logic [STATE_W-1:0] base_next;
    logic               cond_raw, sts, hold;
    src_e               src;

    // Only opcode class bits and the load/store bit feed the encoder.
    logic unused_instr;
    assign unused_instr = ^{instr[31:28], instr[24:21], instr[19:0]};

    // Condition select and optional inversion.
    always_comb begin
        cond_raw = moc;
        unique case (cond_sel)
            2'b00: cond_raw = moc;
            2'b01: cond_raw = cond_pass;
            2'b10: cond_raw = ext_cond;
            2'b11: cond_raw = 1'b1;
        endcase
        sts = cond_raw ^ inv;
    end

    // Instruction encoder: opcode class to first execute microstate.
    always_comb begin
        enc_state = FETCH_S;
        unique case (instr[27:25])
            3'b000:         enc_state = STATE_W'(10);
            3'b001:         enc_state = STATE_W'(11);
            3'b010, 3'b011: enc_state = instr[20] ? STATE_W'(20) : STATE_W'(25);
            3'b101:         enc_state = STATE_W'(30);
            default:        enc_state = FETCH_S;
        endcase
    end

    // Sequencing decode; hold reuses the INC code on src_sel but keeps state.
    always_comb begin
        src  = SRC_INC;
        hold = 1'b0;
        unique case (ns_ctl)
            3'b000: src = SRC_ENC;
            3'b001: src = SRC_FETCH;
            3'b010: src = SRC_CR;
            3'b011: src = SRC_INC;
            3'b100: src = sts ? SRC_CR  : SRC_INC;
            3'b101: src = sts ? SRC_ENC : SRC_INC;
            3'b110: src = sts ? SRC_CR  : SRC_FETCH;
            3'b111: begin
                src  = SRC_INC;
                hold = ~sts;
            end
        endcase
    end

    // Next-state mux.
    always_comb begin
        base_next = inc_q;
        unique case (src)
            SRC_ENC:   base_next = enc_state;
            SRC_FETCH: base_next = FETCH_S;
            SRC_CR:    base_next = cr_next;
            SRC_INC:   base_next = inc_q;
        endcase
        if (hold) base_next = state_q;
    end

`ifdef SEQ_MOC_TIMEOUT_EN
    localparam int CNT_W = (MOC_TIMEOUT > 1) ? $clog2(MOC_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOC_TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;

    // Hold watchdog: a stalled hold is abandoned for the fetch entry.
    always_comb begin
        state_d    = base_next;
        src_sel    = src;
        wait_cnt_d = '0;
        timeout_d  = timeout_q;
        if (hold) begin
            if (wait_cnt_q == CNT_LAST) begin
                state_d   = FETCH_S;
                src_sel   = SRC_FETCH;
                timeout_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
        end
    end

    // Watchdog counter and sticky flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign moc_timeout = timeout_q;
`else
    assign state_d     = base_next;
    assign src_sel     = src;
    assign moc_timeout = 1'b0;
`endif

    // Microstate and incrementer registers; inc wraps naturally at 2**STATE_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RST_S;
            inc_q   <= RST_S + STATE_W'(1);
        end else begin
            state_q <= state_d;
            inc_q   <= state_d + STATE_W'(1);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: table of single-cycle vectors walked in
// order (each expected state hand-derived from the previous), then hand-written
// sequences for reset priority, moc glitches and long holds.
module tb_micro_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [2:0]  ns_ctl;
    logic [5:0]  cr_next;
    logic        inv;
    logic [1:0]  cond_sel;
    logic        moc, cond_pass, ext_cond;
    logic [5:0]  state;
    logic [1:0]  src_sel;
    logic        moc_timeout;

    int errors = 0;
    int checks = 0;

    micro_sequencer dut (
        .clk(clk), .reset(reset), .instr(instr), .ns_ctl(ns_ctl),
        .cr_next(cr_next), .inv(inv), .cond_sel(cond_sel), .moc(moc),
        .cond_pass(cond_pass), .ext_cond(ext_cond), .state(state),
        .src_sel(src_sel), .moc_timeout(moc_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ns;
        logic [5:0] cr;
        logic [2:0] op;
        logic       b20;
        logic       inv;
        logic [1:0] cs;
        logic       moc;
        logic       cp;
        logic       ec;
        logic [1:0] exp_src;
        logic [5:0] exp_state;
    } vec_t;

    vec_t vecs[26];

    function automatic vec_t mk(input logic [2:0] ns, input logic [5:0] cr,
                                input logic [2:0] op, input logic b20,
                                input logic iv, input logic [1:0] cs,
                                input logic m, input logic cp, input logic ec,
                                input logic [1:0] es, input logic [5:0] st);
        vec_t v;
        v.ns = ns; v.cr = cr; v.op = op; v.b20 = b20; v.inv = iv; v.cs = cs;
        v.moc = m; v.cp = cp; v.ec = ec; v.exp_src = es; v.exp_state = st;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ns_ctl    = v.ns;
        cr_next   = v.cr;
        instr     = 32'h0;
        instr[27:25] = v.op;
        instr[20]    = v.b20;
        inv       = v.inv;
        cond_sel  = v.cs;
        moc       = v.moc;
        cond_pass = v.cp;
        ext_cond  = v.ec;
    endtask

    task automatic idle_hold();
        ns_ctl = 3'b111; cond_sel = 2'b00; inv = 1'b0; moc = 1'b0;
    endtask

    initial begin
        // ns    cr  op   b20 inv cs    moc cp ec  src    state
        vecs[0]  = mk(3'b011, 0,  3'b000, 0, 0, 2'b00, 0, 0, 0, 2'b11, 1);
        vecs[1]  = mk(3'b011, 0,  3'b000, 0, 0, 2'b00, 0, 0, 0, 2'b11, 2);
        vecs[2]  = mk(3'b011, 0,  3'b000, 0, 0, 2'b00, 0, 0, 0, 2'b11, 3);
        vecs[3]  = mk(3'b111, 0,  3'b000, 0, 0, 2'b00, 0, 0, 0, 2'b11, 3);
        vecs[4]  = mk(3'b111, 0,  3'b000, 0, 0, 2'b00, 0, 0, 0, 2'b11, 3);
        vecs[5]  = mk(3'b111, 0,  3'b000, 0, 0, 2'b00, 0, 0, 0, 2'b11, 3);
        vecs[6]  = mk(3'b111, 0,  3'b000, 0, 0, 2'b00, 0, 0, 0, 2'b11, 3);
        vecs[7]  = mk(3'b111, 0,  3'b000, 0, 0, 2'b00, 0, 0, 0, 2'b11, 3);
        vecs[8]  = mk(3'b111, 0,  3'b000, 0, 0, 2'b00, 1, 0, 0, 2'b11, 4);
        vecs[9]  = mk(3'b000, 0,  3'b010, 1, 0, 2'b00, 0, 0, 0, 2'b00, 20);
        vecs[10] = mk(3'b000, 0,  3'b010, 0, 0, 2'b00, 0, 0, 0, 2'b00, 25);
        vecs[11] = mk(3'b000, 0,  3'b111, 0, 0, 2'b00, 0, 0, 0, 2'b00, 1);
        vecs[12] = mk(3'b000, 0,  3'b101, 0, 0, 2'b00, 0, 0, 0, 2'b00, 30);
        vecs[13] = mk(3'b100, 30, 3'b000, 0, 0, 2'b01, 0, 0, 0, 2'b11, 31);
        vecs[14] = mk(3'b100, 30, 3'b000, 0, 1, 2'b01, 0, 0, 0, 2'b10, 30);
        vecs[15] = mk(3'b010, 63, 3'b000, 0, 0, 2'b00, 0, 0, 0, 2'b10, 63);
        vecs[16] = mk(3'b011, 0,  3'b000, 0, 0, 2'b00, 0, 0, 0, 2'b11, 0);
        vecs[17] = mk(3'b101, 0,  3'b000, 0, 0, 2'b10, 0, 0, 1, 2'b00, 10);
        vecs[18] = mk(3'b101, 0,  3'b000, 0, 0, 2'b10, 0, 0, 0, 2'b11, 11);
        vecs[19] = mk(3'b110, 45, 3'b000, 0, 1, 2'b11, 0, 0, 0, 2'b01, 1);
        vecs[20] = mk(3'b110, 45, 3'b000, 0, 0, 2'b11, 0, 0, 0, 2'b10, 45);
        vecs[21] = mk(3'b001, 0,  3'b000, 0, 0, 2'b00, 0, 0, 0, 2'b01, 1);
        vecs[22] = mk(3'b000, 0,  3'b001, 0, 0, 2'b00, 0, 0, 0, 2'b00, 11);
        vecs[23] = mk(3'b000, 0,  3'b011, 1, 0, 2'b00, 0, 0, 0, 2'b00, 20);
        vecs[24] = mk(3'b111, 0,  3'b000, 0, 1, 2'b01, 0, 1, 0, 2'b11, 20);
        vecs[25] = mk(3'b111, 0,  3'b000, 0, 0, 2'b11, 0, 0, 0, 2'b11, 21);

        // Reset held two edges, with busy inputs that reset must override.
        reset = 1'b1;
        drive(vecs[15]);
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", state, 0);
        check("reset_timeout", moc_timeout, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 26; i++) begin
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d_src_sel", i), src_sel, vecs[i].exp_src);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_state", i), state, vecs[i].exp_state);
            check($sformatf("v%0d_timeout", i), moc_timeout, 0);
            @(negedge clk);
        end

        // moc pulse between edges must not release a hold.
        idle_hold();
        @(posedge clk);
        #1;
        moc = 1'b1;
        #2;
        moc = 1'b0;
        @(posedge clk);
        #1;
        check("glitch_hold_state", state, 21);

        // Reset during a hold, then incrementer restarts from RESET_STATE+1.
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("hold_reset_state", state, 0);
        @(negedge clk);
        reset = 1'b0;
        ns_ctl = 3'b011;
        @(posedge clk);
        #1;
        check("post_reset_inc", state, 1);

        // Long hold from a state distinct from the fetch entry.
        @(negedge clk);
        ns_ctl = 3'b010; cr_next = 6'd40;
        @(posedge clk);
        #1;
        check("pre_hold_state", state, 40);
        @(negedge clk);
        idle_hold();
`ifdef SEQ_MOC_TIMEOUT_EN
        repeat (15) @(posedge clk);
        #1;
        check("to_hold15_state", state, 40);
        check("to_hold15_flag", moc_timeout, 0);
        @(posedge clk);
        #1;
        check("to_fire_state", state, 1);
        check("to_fire_flag", moc_timeout, 1);
        @(negedge clk);
        ns_ctl = 3'b011;
        @(posedge clk);
        #1;
        check("to_sticky_state", state, 2);
        check("to_sticky_flag", moc_timeout, 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("to_reset_flag", moc_timeout, 0);
        @(negedge clk);
        reset = 1'b0;
`else
        repeat (20) @(posedge clk);
        #1;
        check("long_hold_state", state, 40);
        check("long_hold_flag", moc_timeout, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
